// File: rtl/memoria_programa.sv
// Program memory with random-access and sequential (program-counter) fetch.
// Sequential fetch stops on the OP_HALT opcode until sequencial is dropped.
`timescale 1ns/1ps
module memoria_programa #(
    parameter int unsigned          OPCODE_W = 3,
    parameter int unsigned          VALOR_W  = 4,
    parameter int unsigned          ADDR_W   = 4,
    parameter logic [OPCODE_W-1:0]  OP_HALT  = '1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                escrita,
    input  logic [ADDR_W-1:0]   enderecoEscrita,
    input  logic [OPCODE_W-1:0] instrucaoEntrada,
    input  logic [VALOR_W-1:0]  valorEntrada,
    input  logic                leitura,
    input  logic                sequencial,
    input  logic [ADDR_W-1:0]   posicaoMemoria,
    output logic [OPCODE_W-1:0] instrucao,
    output logic [VALOR_W-1:0]  valor,
    output logic                valido,
    output logic [ADDR_W-1:0]   contador,
    output logic                parado
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        SEQUENCIA = 2'd1,
        PARADO    = 2'd2
    } estado_t;

    estado_t estado, estado_prox;

    logic [OPCODE_W-1:0] mem_op  [DEPTH];
    logic [VALOR_W-1:0]  mem_val [DEPTH];

    logic                busca;
    logic [ADDR_W-1:0]   endereco_busca;
    logic [ADDR_W-1:0]   contador_prox;
    logic                parado_prox;
    logic [OPCODE_W-1:0] op_lido;
    logic [VALOR_W-1:0]  val_lido;

    // Combinational read: the array still holds the pre-write word at this edge
    assign op_lido  = mem_op[endereco_busca];
    assign val_lido = mem_val[endereco_busca];

    // Storage: writes land at the edge, whole array clears on reset
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_op[i]  <= '0;
                mem_val[i] <= '0;
            end
        end else if (escrita) begin
            mem_op[enderecoEscrita]  <= instrucaoEntrada;
            mem_val[enderecoEscrita] <= valorEntrada;
        end
    end

    // State, program counter and registered fetch outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado    <= OCIOSO;
            instrucao <= '0;
            valor     <= '0;
            valido    <= 1'b0;
            contador  <= '0;
            parado    <= 1'b0;
        end else begin
            estado   <= estado_prox;
            contador <= contador_prox;
            parado   <= parado_prox;
            valido   <= busca;
            if (busca) begin
                instrucao <= op_lido;
                valor     <= val_lido;
            end
        end
    end

    // Next-state, fetch address and program-counter update
    always_comb begin
        estado_prox    = estado;
        busca          = 1'b0;
        endereco_busca = posicaoMemoria;
        contador_prox  = contador;
        parado_prox    = parado;

        // Dropping sequencial from any state falls back to a plain random read
        if (!sequencial) begin
            estado_prox = OCIOSO;
            parado_prox = 1'b0;
            busca       = leitura;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (leitura) begin
                        busca = 1'b1;
                        if (op_lido == OP_HALT) begin
                            estado_prox   = PARADO;
                            parado_prox   = 1'b1;
                            contador_prox = posicaoMemoria;
                        end else begin
                            estado_prox   = SEQUENCIA;
                            contador_prox = posicaoMemoria + ADDR_W'(1);
                        end
                    end
                end
                SEQUENCIA: begin
                    endereco_busca = contador;
                    if (leitura) begin
                        busca = 1'b1;
                        if (op_lido == OP_HALT) begin
                            estado_prox = PARADO;
                            parado_prox = 1'b1;
                        end else begin
                            contador_prox = contador + ADDR_W'(1);
                        end
                    end
                end
                PARADO: begin
                    endereco_busca = contador;
                end
                default: begin
                    estado_prox = OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_programa.sv
// Directed bench for memoria_programa: random reads, same-edge read/write,
// sequential fetch with wrap/stall/halt, exit from halt, asynchronous reset.
`timescale 1ns/1ps
module tb_memoria_programa;

    logic       clock;
    logic       reset_n;
    logic       escrita;
    logic [3:0] enderecoEscrita;
    logic [2:0] instrucaoEntrada;
    logic [3:0] valorEntrada;
    logic       leitura;
    logic       sequencial;
    logic [3:0] posicaoMemoria;
    logic [2:0] instrucao;
    logic [3:0] valor;
    logic       valido;
    logic [3:0] contador;
    logic       parado;

    int tests = 0;
    int fails = 0;

    memoria_programa #(
        .OPCODE_W (3),
        .VALOR_W  (4),
        .ADDR_W   (4),
        .OP_HALT  (3'b111)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .escrita          (escrita),
        .enderecoEscrita  (enderecoEscrita),
        .instrucaoEntrada (instrucaoEntrada),
        .valorEntrada     (valorEntrada),
        .leitura          (leitura),
        .sequencial       (sequencial),
        .posicaoMemoria   (posicaoMemoria),
        .instrucao        (instrucao),
        .valor            (valor),
        .valido           (valido),
        .contador         (contador),
        .parado           (parado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full output snapshot: {instrucao, valor, valido, contador, parado}
    task automatic check_all(input string tag, input logic [2:0] i, input logic [3:0] v,
                             input logic vd, input logic [3:0] c, input logic p);
        check({tag, ".instrucao"}, 32'(instrucao), 32'(i));
        check({tag, ".valor"},     32'(valor),     32'(v));
        check({tag, ".valido"},    32'(valido),    32'(vd));
        check({tag, ".contador"},  32'(contador),  32'(c));
        check({tag, ".parado"},    32'(parado),    32'(p));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [2:0] op, input logic [3:0] v);
        escrita          = 1'b1;
        enderecoEscrita  = a;
        instrucaoEntrada = op;
        valorEntrada     = v;
        tick();
        escrita = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; escrita = 1'b0; enderecoEscrita = '0;
        instrucaoEntrada = '0; valorEntrada = '0;
        leitura = 1'b0; sequencial = 1'b0; posicaoMemoria = '0;

        #3;
        check_all("reset", 3'd0, 4'h0, 1'b0, 4'd0, 1'b0);
        #4 reset_n = 1'b1;
        tick();

        // Random write then read
        wr(4'd3, 3'b010, 4'h5);
        leitura = 1'b1; sequencial = 1'b0; posicaoMemoria = 4'd3;
        tick();
        check_all("rd3", 3'b010, 4'h5, 1'b1, 4'd0, 1'b0);
        leitura = 1'b0;
        tick();
        check_all("idle", 3'b010, 4'h5, 1'b0, 4'd0, 1'b0);

        // Same-edge write and read of address 6 returns old word
        escrita = 1'b1; enderecoEscrita = 4'd6; instrucaoEntrada = 3'b001; valorEntrada = 4'hA;
        leitura = 1'b1; posicaoMemoria = 4'd6;
        tick();
        check_all("rw6_old", 3'd0, 4'h0, 1'b1, 4'd0, 1'b0);
        escrita = 1'b0;
        tick();
        check_all("rw6_new", 3'b001, 4'hA, 1'b1, 4'd0, 1'b0);
        leitura = 1'b0;

        // Program across the wrap with HALT at 1
        wr(4'd14, 3'd1, 4'd1);
        wr(4'd15, 3'd2, 4'd2);
        wr(4'd0,  3'd3, 4'd3);
        wr(4'd1,  3'd7, 4'd0);
        leitura = 1'b1; sequencial = 1'b1; posicaoMemoria = 4'd14;
        tick(); check_all("seq1", 3'd1, 4'd1, 1'b1, 4'd15, 1'b0);
        tick(); check_all("seq2", 3'd2, 4'd2, 1'b1, 4'd0,  1'b0);
        tick(); check_all("seq3", 3'd3, 4'd3, 1'b1, 4'd1,  1'b0);
        tick(); check_all("halt", 3'd7, 4'd0, 1'b1, 4'd1,  1'b1);
        tick(); check_all("halt_hold", 3'd7, 4'd0, 1'b0, 4'd1, 1'b1);
        // Write while halted leaves outputs and state untouched
        escrita = 1'b1; enderecoEscrita = 4'd9; instrucaoEntrada = 3'd4; valorEntrada = 4'd4;
        tick(); check_all("halt_wr", 3'd7, 4'd0, 1'b0, 4'd1, 1'b1);
        escrita = 1'b0;

        // Drop sequencial in PARADO: same-edge random read of 15
        sequencial = 1'b0; posicaoMemoria = 4'd15;
        tick(); check_all("exit_halt", 3'd2, 4'd2, 1'b1, 4'd1, 1'b0);
        posicaoMemoria = 4'd9;
        tick(); check_all("rd9", 3'd4, 4'd4, 1'b1, 4'd1, 1'b0);

        // Same program with a two-cycle stall after the second fetch
        sequencial = 1'b1; posicaoMemoria = 4'd14;
        tick(); check_all("st1", 3'd1, 4'd1, 1'b1, 4'd15, 1'b0);
        tick(); check_all("st2", 3'd2, 4'd2, 1'b1, 4'd0,  1'b0);
        leitura = 1'b0;
        tick(); check_all("stall_a", 3'd2, 4'd2, 1'b0, 4'd0, 1'b0);
        tick(); check_all("stall_b", 3'd2, 4'd2, 1'b0, 4'd0, 1'b0);
        leitura = 1'b1;
        tick(); check_all("st3", 3'd3, 4'd3, 1'b1, 4'd1, 1'b0);

        // Asynchronous reset between edges during SEQUENCIA
        #3 reset_n = 1'b0;
        #1 check_all("async_rst", 3'd0, 4'h0, 1'b0, 4'd0, 1'b0);
        #2 reset_n = 1'b1;
        sequencial = 1'b0; leitura = 1'b1; posicaoMemoria = 4'd14;
        tick(); check_all("post_rst14", 3'd0, 4'h0, 1'b1, 4'd0, 1'b0);
        posicaoMemoria = 4'd3;
        tick(); check_all("post_rst3", 3'd0, 4'h0, 1'b1, 4'd0, 1'b0);
        leitura = 1'b0;

        // Sequential start directly on a HALT word
        wr(4'd2, 3'd7, 4'd3);
        leitura = 1'b1; sequencial = 1'b1; posicaoMemoria = 4'd2;
        tick(); check_all("start_halt", 3'd7, 4'd3, 1'b1, 4'd2, 1'b1);
        tick(); check_all("start_halt_hold", 3'd7, 4'd3, 1'b0, 4'd2, 1'b1);

        // Sequential start at 15 wraps the counter to 0
        sequencial = 1'b0; leitura = 1'b0;
        tick();
        wr(4'd15, 3'd5, 4'd6);
        leitura = 1'b1; sequencial = 1'b1; posicaoMemoria = 4'd15;
        tick(); check_all("wrap15", 3'd5, 4'd6, 1'b1, 4'd0, 1'b0);
        leitura = 1'b0; sequencial = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/memoria_programa.md
MEMORIA_PROGRAMA -- requirements
Module: memoria_programa

Interface
REQ-001 SHALL have parameter OPCODE_W, default 3, instruction opcode width.
REQ-002 SHALL have parameter VALOR_W, default 4, operand width.
REQ-003 SHALL have parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W words.
REQ-004 SHALL have parameter OP_HALT, default all-ones (3'b111), opcode that stops sequential fetch.
REQ-005 SHALL have ports:
- clock  input  1  single clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- escrita  input  1  write enable
- enderecoEscrita  input  ADDR_W  write address
- instrucaoEntrada  input  OPCODE_W  opcode to write
- valorEntrada  input  VALOR_W  operand to write
- leitura  input  1  fetch request
- sequencial  input  1  1 = sequential (program-counter) mode, 0 = random access
- posicaoMemoria  input  ADDR_W  read address, or start address in sequential mode
- instrucao  output  OPCODE_W  fetched opcode (registered)
- valor  output  VALOR_W  fetched operand (registered)
- valido  output  1  instrucao/valor updated at the last edge
- contador  output  ADDR_W  current program counter
- parado  output  1  sequential fetch halted on OP_HALT

Function
REQ-006 SHALL store DEPTH words of {opcode, operand}; escrita=1 at an edge writes instrucaoEntrada/valorEntrada to enderecoEscrita.
REQ-007 SHALL return old contents when a read and a write hit the same address at the same edge; the new word is readable from the next edge.
REQ-008 SHALL implement states OCIOSO, SEQUENCIA, PARADO.
REQ-009 OCIOSO, leitura=1, sequencial=0: at edge, instrucao/valor <= word at posicaoMemoria, valido <= 1 (latency 1 edge); contador unchanged.
REQ-010 OCIOSO, leitura=1, sequencial=1: at edge, fetch word at posicaoMemoria, valido <= 1, contador <= posicaoMemoria+1 (mod DEPTH), go SEQUENCIA; if fetched opcode = OP_HALT go PARADO and contador <= posicaoMemoria instead.
REQ-011 SEQUENCIA, sequencial=1, leitura=1: at edge, fetch word at contador, valido <= 1, contador <= contador+1, wrapping DEPTH-1 -> 0.
REQ-012 SEQUENCIA, fetched opcode = OP_HALT: that word SHALL be output with valido=1, contador SHALL hold the HALT address, state -> PARADO, parado <= 1.
REQ-013 SEQUENCIA, leitura=0: stall; valido <= 0, contador and outputs hold.
REQ-014 SEQUENCIA or PARADO, sequencial=0: state -> OCIOSO at that edge, parado <= 0, and the edge SHALL be processed under REQ-009 rules.
REQ-015 PARADO, sequencial=1: no fetch regardless of leitura; valido <= 0, contador/instrucao/valor hold, parado stays 1.
REQ-016 Any edge without a fetch SHALL drive valido <= 0 and hold instrucao/valor.
REQ-017 Writes SHALL be accepted in every state and never alter state, contador or outputs at that edge.

Reset
REQ-018 reset_n=0 SHALL immediately, independent of clock, set state OCIOSO, instrucao=0, valor=0, valido=0, contador=0, parado=0, and clear all DEPTH words to zero.
REQ-019 Reset asserted mid-sequence SHALL abandon the sequence; after release the first fetch follows OCIOSO rules.

Verification
REQ-020 Write {3'b010,4'h5} at 3, next cycle random read 3 -> after edge instrucao=3'b010, valor=4'h5, valido=1; idle cycle -> valido=0, outputs hold.
REQ-021 Same-edge write {3'b001,4'hA} and read at 6 (previously {0,0}) -> outputs {0,0}; read again next edge -> {3'b001,4'hA}.
REQ-022 Load addr 14 {1,1}, 15 {2,2}, 0 {3,3}, 1 {7,0}; sequencial=1, leitura=1, posicaoMemoria=14 -> outputs 1,2,3,7 on four consecutive edges, contador 15,0,1,1, parado=1 after 4th edge; further edges valido=0.
REQ-023 Same program, leitura low for 2 cycles after 2nd fetch -> valido=0 and contador=0 held for those cycles, sequence resumes with {3,3}.
REQ-024 Assert reset_n=0 between clock edges during SEQUENCIA -> all outputs 0 immediately; after release a read of any address returns {0,0}.
REQ-025 In PARADO drop sequencial with leitura=1, posicaoMemoria=15 -> same edge returns {2,2}, parado=0, state OCIOSO.
